mux_serializer: RTL and testbench

- Sequential front-end for the 8:1 multiplexer stage.
- Accepts an 8-bit word over a valid/ready handshake and holds it on the multiplexer data inputs.
- Steps the shared 3-bit select address through all eight positions, taking the multiplexer output bit back each cycle.
- Presents the result as a serial bit stream with its own valid/ready handshake and a last-bit marker. Replaces the static address currently tied to the MUX/DMX select inputs.

---
 rtl/mux_serializer_pkg.sv | 23 ++
 rtl/mux_serializer_if.sv | 29 ++
 rtl/mux_serializer.sv | 101 ++++++++++
 tb/tb_mux_serializer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_serializer_pkg.sv
// rtl/mux_serializer_pkg.sv - shared widths, state encoding and select-order helpers
package mux_serializer_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } serState;

  // First select position of a frame for the chosen bit order.
  function automatic logic [ADDR_W-1:0] addrFirst(input bit lsbFirst);
    return lsbFirst ? '0 : '1;
  endfunction

  // Final select position of a frame for the chosen bit order.
  function automatic logic [ADDR_W-1:0] addrLast(input bit lsbFirst);
    return lsbFirst ? '1 : '0;
  endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// rtl/mux_serializer_if.sv - word-in, mux select/return and serial-out signal bundle
interface mux_serializer_if;
  import mux_serializer_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] mux_data;
  logic [ADDR_W-1:0] addr;
  logic              mux_bit;
  logic              ser_valid;
  logic              ser_ready;
  logic              ser_data;
  logic              ser_last;
  logic              busy;

  // Serializer side: owns the select address and the serial stream.
  modport master (
    input  in_valid, in_data, mux_bit, ser_ready,
    output in_ready, mux_data, addr, ser_valid, ser_data, ser_last, busy
  );

  // Environment side: word producer, multiplexer and serial consumer.
  modport slave (
    output in_valid, in_data, mux_bit, ser_ready,
    input  in_ready, mux_data, addr, ser_valid, ser_data, ser_last, busy
  );

endinterface

// File: rtl/mux_serializer.sv
// rtl/mux_serializer.sv - steps the 8:1 mux select through a latched word to form a serial stream
module mux_serializer
  import mux_serializer_pkg::*;
#(
  parameter bit LSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  mux_serializer_if.master bus
);

  localparam logic [ADDR_W-1:0] ADDR_FIRST = addrFirst(LSB_FIRST);
  localparam logic [ADDR_W-1:0] ADDR_LAST  = addrLast(LSB_FIRST);
  localparam bit                HAS_GAP    = (GAP_CYCLES > 0);
  // Value of the gap counter on the final idle cycle; unused when there is no gap.
  localparam logic [3:0]        GAP_LAST   = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  serState           state;
  serState           nextState;
  logic [DATA_W-1:0] muxData;
  logic [ADDR_W-1:0] addrReg;
  logic [3:0]        gapCnt;
  logic              loadWord;
  logic              stepAddr;
  logic              isLast;
  logic              inReady;
  logic              serValid;

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Word latch, select address stepping and inter-frame gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      muxData <= '0;
      addrReg <= '0;
      gapCnt  <= '0;
    end else begin
      if (loadWord) begin
        muxData <= bus.in_data;
        addrReg <= ADDR_FIRST;
      end else if (stepAddr) begin
        addrReg <= LSB_FIRST ? addrReg + 3'd1 : addrReg - 3'd1;
      end
      gapCnt <= (state == GAP) ? gapCnt + 4'd1 : 4'd0;
    end
  end

  // Next-state decode and handshake outputs; ser_data is the raw mux return bit.
  always_comb begin
    nextState = state;
    loadWord  = 1'b0;
    stepAddr  = 1'b0;
    isLast    = (addrReg == ADDR_LAST);
    // in_ready is held low during reset even though state already reads IDLE.
    inReady   = rst_n && (state == IDLE);
    serValid  = (state == SHIFT);

    case (state)
      IDLE: begin
        if (bus.in_valid && inReady) begin
          loadWord  = 1'b1;
          nextState = SHIFT;
        end
      end
      SHIFT: begin
        if (bus.ser_ready) begin
          if (isLast) begin
            nextState = HAS_GAP ? GAP : IDLE;
          end else begin
            stepAddr = 1'b1;
          end
        end
      end
      GAP: begin
        if (gapCnt == GAP_LAST) begin
          nextState = IDLE;
        end
      end
      default: begin
        nextState = IDLE;
      end
    endcase

    bus.in_ready  = inReady;
    bus.ser_valid = serValid;
    bus.ser_last  = serValid && isLast;
    bus.ser_data  = bus.mux_bit;
    bus.busy      = (state != IDLE);
    bus.mux_data  = muxData;
    bus.addr      = addrReg;
  end

endmodule

// File: tb/tb_mux_serializer.sv
// tb/tb_mux_serializer.sv - directed self-checking bench for mux_serializer
module tb_mux_serializer;
  import mux_serializer_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nTests = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  mux_serializer_if ifA ();
  mux_serializer_if ifB ();
  mux_serializer_if ifC ();

  // 8:1 multiplexer between latched word/select and the return bit.
  assign ifA.mux_bit = ifA.mux_data[ifA.addr];
  assign ifB.mux_bit = ifB.mux_data[ifB.addr];
  assign ifC.mux_bit = ifC.mux_data[ifC.addr];

  mux_serializer #(.LSB_FIRST(1'b1), .GAP_CYCLES(0)) dutA (.clk(clk), .rst_n(rst_n), .bus(ifA.master));
  mux_serializer #(.LSB_FIRST(1'b0), .GAP_CYCLES(0)) dutB (.clk(clk), .rst_n(rst_n), .bus(ifB.master));
  mux_serializer #(.LSB_FIRST(1'b1), .GAP_CYCLES(3)) dutC (.clk(clk), .rst_n(rst_n), .bus(ifC.master));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] got;
    rst_n = 1'b0;
    step();
    step();
    got = {ifA.in_ready, ifA.ser_valid, ifA.ser_last, ifA.busy, ifA.addr, ifA.mux_data};
    nTests++;
    if (got !== 15'h0) begin
      $display("FAIL reset_state_a got=%h exp=%h", got, 15'h0);
      nFail++;
    end
    got = {ifC.in_ready, ifC.ser_valid, ifC.ser_last, ifC.busy, ifC.addr, ifC.mux_data};
    nTests++;
    if (got !== 15'h0) begin
      $display("FAIL reset_state_c got=%h exp=%h", got, 15'h0);
      nFail++;
    end
    rst_n = 1'b1;
    step();
    nTests++;
    if ({ifA.in_ready, ifB.in_ready, ifC.in_ready} !== 3'b111) begin
      $display("FAIL reset_release_ready got=%b exp=111", {ifA.in_ready, ifB.in_ready, ifC.in_ready});
      nFail++;
    end
  endtask

  task automatic test_lsb_first();
    bit expSeq [8];
    logic [5:0] got, exp;
    expSeq = '{1, 0, 1, 0, 0, 1, 0, 1};
    ifA.in_valid = 1'b1;
    ifA.in_data  = 8'hA5;
    nTests++;
    if (ifA.in_ready !== 1'b1) begin
      $display("FAIL lsb_in_ready got=%b exp=1", ifA.in_ready);
      nFail++;
    end
    step();
    ifA.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {ifA.ser_valid, ifA.addr, ifA.ser_data, ifA.ser_last};
      exp = {1'b1, 3'(i), expSeq[i], (i == 7)};
      nTests++;
      if (got !== exp) begin
        $display("FAIL lsb_bit%0d {valid,addr,data,last} got=%b exp=%b", i, got, exp);
        nFail++;
      end
      step();
    end
    nTests++;
    if ({ifA.in_ready, ifA.ser_valid, ifA.busy} !== 3'b100) begin
      $display("FAIL lsb_end {ready,valid,busy} got=%b exp=100", {ifA.in_ready, ifA.ser_valid, ifA.busy});
      nFail++;
    end
  endtask

  task automatic test_msb_first();
    bit expSeq [8];
    logic [5:0] got, exp;
    expSeq = '{1, 0, 0, 0, 0, 0, 0, 1};
    ifB.in_valid = 1'b1;
    ifB.in_data  = 8'h81;
    step();
    ifB.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {ifB.ser_valid, ifB.addr, ifB.ser_data, ifB.ser_last};
      exp = {1'b1, 3'(7 - i), expSeq[i], (i == 7)};
      nTests++;
      if (got !== exp) begin
        $display("FAIL msb_bit%0d {valid,addr,data,last} got=%b exp=%b", i, got, exp);
        nFail++;
      end
      step();
    end
    nTests++;
    if ({ifB.in_ready, ifB.ser_valid} !== 2'b10) begin
      $display("FAIL msb_end {ready,valid} got=%b exp=10", {ifB.in_ready, ifB.ser_valid});
      nFail++;
    end
  endtask

  task automatic test_backpressure();
    int  addrSeq [11];
    bit  rdySeq  [11];
    bit  dataSeq [11];
    logic [5:0] got, exp;
    addrSeq = '{0, 1, 2, 2, 2, 2, 3, 4, 5, 6, 7};
    rdySeq  = '{1, 1, 0, 0, 0, 1, 1, 1, 1, 1, 1};
    dataSeq = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    ifA.in_valid = 1'b1;
    ifA.in_data  = 8'h3C;
    step();
    ifA.in_valid = 1'b0;
    for (int i = 0; i < 11; i++) begin
      ifA.ser_ready = rdySeq[i];
      got = {ifA.ser_valid, ifA.addr, ifA.ser_data, ifA.ser_last};
      exp = {1'b1, 3'(addrSeq[i]), dataSeq[i], (i == 10)};
      nTests++;
      if (got !== exp) begin
        $display("FAIL bp_cycle%0d {valid,addr,data,last} got=%b exp=%b", i, got, exp);
        nFail++;
      end
      step();
    end
    ifA.ser_ready = 1'b1;
    nTests++;
    if ({ifA.in_ready, ifA.ser_valid} !== 2'b10) begin
      $display("FAIL bp_frame_len {ready,valid} got=%b exp=10", {ifA.in_ready, ifA.ser_valid});
      nFail++;
    end
  endtask

  task automatic test_reset_mid_frame();
    bit expSeq [8];
    logic [5:0]  got, exp;
    logic [14:0] gotR;
    expSeq = '{1, 0, 0, 0, 0, 0, 0, 0};
    ifA.in_valid = 1'b1;
    ifA.in_data  = 8'hFF;
    step();
    ifA.in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
    end
    nTests++;
    if ({ifA.ser_valid, ifA.addr} !== 4'b1011) begin
      $display("FAIL rst_mid_pre {valid,addr} got=%b exp=1011", {ifA.ser_valid, ifA.addr});
      nFail++;
    end
    rst_n = 1'b0;
    #1;
    gotR = {ifA.in_ready, ifA.ser_valid, ifA.ser_last, ifA.busy, ifA.addr, ifA.mux_data};
    nTests++;
    if (gotR !== 15'h0) begin
      $display("FAIL rst_mid_abort got=%h exp=%h", gotR, 15'h0);
      nFail++;
    end
    step();
    rst_n = 1'b1;
    step();
    ifA.in_valid = 1'b1;
    ifA.in_data  = 8'h01;
    step();
    ifA.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      got = {ifA.ser_valid, ifA.addr, ifA.ser_data, ifA.ser_last};
      exp = {1'b1, 3'(i), expSeq[i], (i == 7)};
      nTests++;
      if (got !== exp) begin
        $display("FAIL rst_mid_next_bit%0d {valid,addr,data,last} got=%b exp=%b", i, got, exp);
        nFail++;
      end
      step();
    end
  endtask

  task automatic test_gap();
    bit expSeq [8];
    logic [6:0] got, exp;
    expSeq = '{1, 1, 1, 1, 0, 0, 0, 0};
    ifC.in_valid = 1'b1;
    ifC.in_data  = 8'h0F;
    step();
    ifC.in_data  = 8'hF0;
    for (int i = 0; i < 8; i++) begin
      got = {ifC.ser_valid, ifC.addr, ifC.ser_data, ifC.ser_last, ifC.in_ready};
      exp = {1'b1, 3'(i), expSeq[i], (i == 7), 1'b0};
      nTests++;
      if (got !== exp) begin
        $display("FAIL gap_bit%0d {valid,addr,data,last,ready} got=%b exp=%b", i, got, exp);
        nFail++;
      end
      step();
    end
    // Three idle cycles follow the last-bit accept; the fourth cycle takes the next word.
    for (int k = 0; k < 3; k++) begin
      nTests++;
      if ({ifC.busy, ifC.in_ready, ifC.ser_valid} !== 3'b100) begin
        $display("FAIL gap_idle%0d {busy,ready,valid} got=%b exp=100", k, {ifC.busy, ifC.in_ready, ifC.ser_valid});
        nFail++;
      end
      step();
    end
    nTests++;
    if ({ifC.busy, ifC.in_ready} !== 2'b01) begin
      $display("FAIL gap_reaccept {busy,ready} got=%b exp=01", {ifC.busy, ifC.in_ready});
      nFail++;
    end
    step();
    ifC.in_valid = 1'b0;
    nTests++;
    if ({ifC.mux_data, ifC.ser_valid, ifC.addr} !== {8'hF0, 1'b1, 3'd0}) begin
      $display("FAIL gap_second_word {mux_data,valid,addr} got=%h exp=%h", {ifC.mux_data, ifC.ser_valid, ifC.addr}, {8'hF0, 1'b1, 3'd0});
      nFail++;
    end
    for (int i = 0; i < 11; i++) begin
      step();
    end
    nTests++;
    if ({ifC.in_ready, ifC.busy} !== 2'b10) begin
      $display("FAIL gap_drain {ready,busy} got=%b exp=10", {ifC.in_ready, ifC.busy});
      nFail++;
    end
  endtask

  task automatic test_in_data_toggle();
    bit expSeq [8];
    logic [13:0] got, exp;
    expSeq = '{0, 1, 1, 0, 1, 0, 0, 1};
    ifA.in_valid = 1'b1;
    ifA.in_data  = 8'h96;
    step();
    ifA.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ifA.in_data = (i % 2 == 0) ? 8'h00 : 8'hFF;
      #1;
      got = {ifA.mux_data, ifA.ser_valid, ifA.addr, ifA.ser_data, ifA.ser_last};
      exp = {8'h96, 1'b1, 3'(i), expSeq[i], (i == 7)};
      nTests++;
      if (got !== exp) begin
        $display("FAIL toggle_bit%0d {mux_data,valid,addr,data,last} got=%h exp=%h", i, got, exp);
        nFail++;
      end
      step();
    end
    nTests++;
    if ({ifA.in_ready, ifA.mux_data} !== {1'b1, 8'h96}) begin
      $display("FAIL toggle_end {ready,mux_data} got=%h exp=%h", {ifA.in_ready, ifA.mux_data}, {1'b1, 8'h96});
      nFail++;
    end
  endtask

  initial begin
    ifA.in_valid = 1'b0; ifA.in_data = 8'h00; ifA.ser_ready = 1'b1;
    ifB.in_valid = 1'b0; ifB.in_data = 8'h00; ifB.ser_ready = 1'b1;
    ifC.in_valid = 1'b0; ifC.in_data = 8'h00; ifC.ser_ready = 1'b1;
    test_reset();
    test_lsb_first();
    test_msb_first();
    test_backpressure();
    test_reset_mid_frame();
    test_gap();
    test_in_data_toggle();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
